// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite slave definitions: response codes and the slave-side FSM states.
// Used by both the read and write slave paths.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    CAP,
    RESP
  } axi_state_e;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational byte-address decode into a register word index plus error class.
// Shared by the read and write slave paths.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic [1:0]        err_resp
);

  always_comb begin
    idx      = addr[IDX_W+1:2];
    err_resp = RESP_OKAY;
    // Misalignment is reported ahead of an out-of-range address.
    if (addr[1:0] != 2'b00)
      err_resp = RESP_SLVERR;
    else if (((addr >> (IDX_W + 2)) != '0) || (32'(idx) >= NUM_REGS))
      err_resp = RESP_DECERR;
  end

endmodule

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read slave: one AR handshake, single-cycle bank read, registered R response
// held until RREADY.
//
// state | meaning
// IDLE  | ARREADY high, waiting for an AR handshake
// RD    | reg_rd_en strobe to the bank (suppressed on a decode error)
// CAP   | capture bank data / error code into the R registers
// RESP  | RVALID high, waiting for RREADY
module axi_lite_read_slave
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              reg_rd_en,
  output logic [IDX_W-1:0]  reg_addr,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_err
);

  axi_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        dec_err_q;
  logic [2:0]        arprot_q;
  logic [IDX_W-1:0]  dec_idx;
  logic [1:0]        dec_err;
  logic              ar_hs;
  logic              unused_ok;

  axi_lite_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr     (ARADDR),
    .idx      (dec_idx),
    .err_resp (dec_err)
  );

  assign ar_hs     = ARVALID && ARREADY;
  assign reg_addr  = idx_q;
  assign reg_rd_en = (state_q == RD) && (dec_err_q == RESP_OKAY);
  // Protection bits are kept with the transaction but nothing here acts on them.
  assign unused_ok = ^arprot_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = RD;
      RD:      state_d = CAP;
      CAP:     state_d = RESP;
      RESP:    if (RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      ARREADY   <= 1'b0;
      RVALID    <= 1'b0;
      RDATA     <= '0;
      RRESP     <= RESP_OKAY;
      idx_q     <= '0;
      dec_err_q <= RESP_OKAY;
      arprot_q  <= '0;
    end else begin
      state_q <= state_d;
      ARREADY <= (state_d == IDLE);
      if (state_q == IDLE && ar_hs) begin
        idx_q     <= dec_idx;
        dec_err_q <= dec_err;
        arprot_q  <= ARPROT;
      end
      if (state_q == CAP) begin
        RVALID <= 1'b1;
        if (dec_err_q == RESP_OKAY) begin
          RDATA <= reg_rdata;
          RRESP <= reg_err ? RESP_SLVERR : RESP_OKAY;
        end else begin
          RDATA <= '0;
          RRESP <= dec_err_q;
        end
      end
      if (state_q == RESP && RREADY) begin
        RVALID <= 1'b0;
        RDATA  <= '0;
        RRESP  <= RESP_OKAY;
      end
    end
  end

endmodule

// File: doc/axi_lite_read_slave.md
# axi_lite_read_slave

AXI4-Lite slave-side read controller. It accepts a read address on the AR channel and performs a single-cycle-latency read of a local register bank. It then presents RDATA/RRESP with RVALID, holding them until RREADY. It sits directly upstream of the read-data channel stage and produces the RVALID/RDATA/RRESP that stage forwards to the master.

## Interface
Parameters:
- ADDR_W, 32, AR address width.
- DATA_W, 32, data width; fixed at 32 for AXI4-Lite.
- NUM_REGS, 16, number of 32-bit words in the register bank. Word index is ARADDR[log2(NUM_REGS)+1:2].

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready (registered).
- ARADDR  in  ADDR_W  byte address.
- ARPROT  in  3  protection; captured, not interpreted.
- RVALID  out  1  read data valid (registered).
- RREADY  in  1  read data ready from the downstream stage.
- RDATA  out  32  read data (registered).
- RRESP  out  2  read response (registered).
- reg_rd_en  out  1  one-cycle read strobe to the register bank.
- reg_addr  out  log2(NUM_REGS)  word index to the bank.
- reg_rdata  in  32  bank data, valid the cycle after reg_rd_en.
- reg_err  in  1  bank error, valid with reg_rdata.

## Operation
- Reset, on any edge with ARESET=1, from any state: state=IDLE; ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, reg_rd_en=0.
- IDLE: ARREADY=1, starting from the first edge with ARESET=0. An AR handshake is ARVALID&ARREADY at an edge. On handshake:
  - latch ARADDR and ARPROT;
  - decode the error class;
  - ARREADY<=0, next state RD.
- Decode:
  - ARADDR[1:0]!=0 → SLVERR (2'b10).
  - Word index ≥ NUM_REGS, or any ARADDR bit above the index field nonzero → DECERR (2'b11).
  - Misalignment takes priority over DECERR.
- RD: reg_rd_en=1 for exactly this cycle, with reg_addr driven, unless a decode error is pending. Next state CAP.
- CAP: on the edge, RVALID<=1. Next state RESP.
  - No decode error: RDATA<=reg_rdata; RRESP<=reg_err ? SLVERR : OKAY.
  - Decode error: RDATA<=0; RRESP<=decoded code.
- RESP: RVALID, RDATA and RRESP are held stable while RREADY=0. On RVALID&RREADY at an edge:
  - RVALID<=0, RDATA<=0, RRESP<=OKAY;
  - ARREADY<=1, state<=IDLE.
- EXOKAY is never generated.
- ARVALID is ignored outside IDLE. ARREADY=0 guarantees no second address is accepted.
- RREADY high before RVALID is legal and has no effect until RVALID=1.

## Timing
- AR handshake at edge k:
  - ARREADY low after k;
  - reg_rd_en high for cycle k..k+1;
  - reg_rdata sampled at edge k+2;
  - RVALID high after edge k+2.
- Address-to-RVALID latency is 2 cycles, identical for error and non-error reads.
- R handshake at edge m: RVALID low and ARREADY high after m. The next AR handshake is possible at edge m+1.
- Maximum throughput: one read per 4 cycles when RREADY is held high.
- ARESET asserted mid-read in RD, CAP or RESP:
  - the transaction is dropped;
  - outputs take reset values at that edge;
  - no reg_rd_en after that edge.

## Structure
- Shared package axi_lite_pkg:
  - response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - FSM state enum {IDLE, RD, CAP, RESP}.
  - The write-side slave reuses both.
- One sub-module is natural: axi_lite_addr_decode. It is combinational; it maps ADDR_W address to a word index plus error class, and is shared with the write path.

## Test plan
- Reset then a single read: reg_rdata=32'hDEADBEEF, reg_err=0, ARADDR=0x8 → reg_addr=2 pulses one cycle; RVALID 2 cycles after the handshake with RDATA=0xDEADBEEF, RRESP=00.
- RREADY held low 5 cycles after RVALID → RVALID/RDATA/RRESP stable for all 5; ARREADY stays 0; ARVALID pulses are ignored.
- ARADDR=0x6 (misaligned) → no reg_rd_en; RDATA=0, RRESP=10. ARADDR=0x40 with NUM_REGS=16 → RRESP=11.
- reg_err=1 on a read of 0x4 → RRESP=10, RDATA=reg_rdata.
- Back-to-back reads with RREADY=1 and ARVALID=1 continuously → one handshake every 4 cycles; data order matches address order.
- ARESET pulsed one cycle while in CAP → RVALID never asserts; ARREADY=1 one cycle after ARESET falls; the following read completes normally.
